// File: rtl/alu_mc_pkg.sv
// Shared ALU opcode encodings, FSM state type and mult/div helpers for alu_mc.
`timescale 1ns/1ps
package alu_mc_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ITER_DEF = 32;

    localparam logic [4:0] ALUOP_NOP   = 5'd0;
    localparam logic [4:0] ALUOP_ADD   = 5'd1;
    localparam logic [4:0] ALUOP_SUB   = 5'd2;
    localparam logic [4:0] ALUOP_SLT   = 5'd3;
    localparam logic [4:0] ALUOP_SLTU  = 5'd4;
    localparam logic [4:0] ALUOP_AND   = 5'd5;
    localparam logic [4:0] ALUOP_OR    = 5'd6;
    localparam logic [4:0] ALUOP_NOR   = 5'd7;
    localparam logic [4:0] ALUOP_LUI   = 5'd8;
    localparam logic [4:0] ALUOP_SLL   = 5'd9;
    localparam logic [4:0] ALUOP_SRL   = 5'd10;
    localparam logic [4:0] ALUOP_SRA   = 5'd11;
    localparam logic [4:0] ALUOP_MULT  = 5'd12;
    localparam logic [4:0] ALUOP_MULTU = 5'd13;
    localparam logic [4:0] ALUOP_DIV   = 5'd14;
    localparam logic [4:0] ALUOP_DIVU  = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_mdu(input logic [4:0] op);
        return (op == ALUOP_MULT) || (op == ALUOP_MULTU) ||
               (op == ALUOP_DIV)  || (op == ALUOP_DIVU);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
    endfunction

    function automatic logic is_signed_mdu(input logic [4:0] op);
        return (op == ALUOP_MULT) || (op == ALUOP_DIV);
    endfunction

endpackage

// File: rtl/alu_mc_mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// {hi,lo} accumulator and an iteration counter.
`timescale 1ns/1ps
module mdu_iter
    import alu_mc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ITER = ITER_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              div_i,
    input  logic [XLEN-1:0]   opa_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              last_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              div_q, div_d;
    logic [5:0]        cnt_q, cnt_d;

    logic [XLEN-1:0]   hi, lo;
    logic [XLEN:0]     sum, trial, diff;

    assign hi    = acc_q[2*XLEN-1:XLEN];
    assign lo    = acc_q[XLEN-1:0];
    assign sum   = {1'b0, hi} + {1'b0, b_q};
    assign trial = {hi, lo[XLEN-1]};
    assign diff  = trial - {1'b0, b_q};

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, opa_i};
            b_d   = opb_i;
            div_d = div_i;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 6'd1;
            if (div_q) begin
                // No borrow means the partial remainder covers the divisor.
                if (!diff[XLEN]) begin
                    acc_d = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {trial[XLEN-1:0], lo[XLEN-2:0], 1'b0};
                end
            end else if (lo[0]) begin
                acc_d = {sum, lo[XLEN-1:1]};
            end else begin
                acc_d = {1'b0, hi, lo[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == 6'(ITER - 1));

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add/shift ops and iterative
// signed/unsigned multiply and divide returning a {hi,lo} result.
`timescale 1ns/1ps
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ITER = ITER_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [4:0]        aluop_i,
    input  logic [XLEN-1:0]   src0_i,
    input  logic [XLEN-1:0]   src1_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*XLEN-1:0] aluout_o,
    output logic              zero_o
);

    localparam int SHW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   src0_q, src1_q;
    logic [2*XLEN-1:0] aluout_q, aluout_d;
    logic              zero_q;

    logic              accept, start_mdu;
    logic [XLEN-1:0]   mag0, mag1, single_lo;
    logic [2*XLEN-1:0] mdu_acc, fix_res;
    logic              mdu_last;
    logic              sgn0, sgn1;
    logic [XLEN-1:0]   quo, rem;

    assign accept    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign start_mdu = accept && is_mdu(aluop_i);

    // Signed ops run the unsigned core on magnitudes; signs are restored in FIX.
    assign mag0 = (is_signed_mdu(aluop_i) && src0_i[XLEN-1]) ? -src0_i : src0_i;
    assign mag1 = (is_signed_mdu(aluop_i) && src1_i[XLEN-1]) ? -src1_i : src1_i;

    mdu_iter #(
        .XLEN(XLEN),
        .ITER(ITER)
    ) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_mdu),
        .step_i (state_q == ST_CALC),
        .div_i  (is_div(aluop_i)),
        .opa_i  (mag0),
        .opb_i  (mag1),
        .acc_o  (mdu_acc),
        .last_o (mdu_last)
    );

    always_comb begin
        single_lo = '0;
        case (aluop_i)
            ALUOP_ADD:  single_lo = src0_i + src1_i;
            ALUOP_SUB:  single_lo = src0_i - src1_i;
            ALUOP_SLT:  single_lo = {{(XLEN-1){1'b0}}, $signed(src0_i) < $signed(src1_i)};
            ALUOP_SLTU: single_lo = {{(XLEN-1){1'b0}}, src0_i < src1_i};
            ALUOP_AND:  single_lo = src0_i & src1_i;
            ALUOP_OR:   single_lo = src0_i | src1_i;
            ALUOP_NOR:  single_lo = ~(src0_i | src1_i);
            ALUOP_LUI:  single_lo = src1_i << 16;
            ALUOP_SLL:  single_lo = src1_i << src0_i[SHW-1:0];
            ALUOP_SRL:  single_lo = src1_i >> src0_i[SHW-1:0];
            ALUOP_SRA:  single_lo = $unsigned($signed(src1_i) >>> src0_i[SHW-1:0]);
            default:    single_lo = '0;
        endcase
    end

    assign sgn0 = is_signed_mdu(op_q) && src0_q[XLEN-1];
    assign sgn1 = is_signed_mdu(op_q) && src1_q[XLEN-1];

    always_comb begin
        quo     = mdu_acc[XLEN-1:0];
        rem     = mdu_acc[2*XLEN-1:XLEN];
        fix_res = mdu_acc;
        if (is_div(op_q)) begin
            if (src1_q == '0) begin
                quo = '1;
                rem = src0_q;
            end else begin
                if (sgn0 ^ sgn1) quo = -quo;
                if (sgn0)        rem = -rem;
            end
            fix_res = {rem, quo};
        end else if (sgn0 ^ sgn1) begin
            fix_res = -mdu_acc;
        end
    end

    always_comb begin
        aluout_d = aluout_q;
        if (accept && !is_mdu(aluop_i)) begin
            aluout_d = {{XLEN{1'b0}}, single_lo};
        end else if (state_q == ST_FIX) begin
            aluout_d = fix_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= ALUOP_NOP;
            src0_q   <= '0;
            src1_q   <= '0;
            aluout_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= aluop_i;
                src0_q <= src0_i;
                src1_q <= src1_i;
            end
            aluout_q <= aluout_d;
            zero_q   <= (aluout_d[XLEN-1:0] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) state_d = is_mdu(aluop_i) ? ST_CALC : ST_DONE;
                else         state_d = ST_IDLE;
            end
            ST_CALC: if (mdu_last) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_CALC) || (state_q == ST_FIX);
        done_o = (state_q == ST_DONE);
    end

    assign aluout_o = aluout_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc with hand-computed expected results.
`timescale 1ns/1ps
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [4:0]  aluop_i = 5'd0;
    logic [31:0] src0_i = '0;
    logic [31:0] src1_i = '0;
    logic        busy_o, done_o, zero_o;
    logic [63:0] aluout_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_mc #(
        .XLEN(32),
        .ITER(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .aluop_i  (aluop_i),
        .src0_i   (src0_i),
        .src1_i   (src1_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .aluout_o (aluout_o),
        .zero_o   (zero_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; returns at the falling edge of cycle 1 after acceptance.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_i = 1'b1;
        aluop_i = op;
        src0_i  = a;
        src1_i  = b;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n, output logic busy_ok);
        n = n0;
        busy_ok = 1'b1;
        while (!done_o && n < 100) begin
            if (!busy_o) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic single(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input logic zexp);
        issue(op, a, b);
        chk({tag, "_done"}, {63'd0, done_o}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
        chk({tag, "_out"}, aluout_o, exp);
        chk({tag, "_zero"}, {63'd0, zero_o}, {63'd0, zexp});
    endtask

    task automatic multi(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
        int n;
        logic bok;
        issue(op, a, b);
        wait_done(1, n, bok);
        chk({tag, "_lat"}, 64'(n), 64'd34);
        chk({tag, "_busy"}, {63'd0, bok}, 64'd1);
        chk({tag, "_out"}, aluout_o, exp);
        chk({tag, "_zero"}, {63'd0, zero_o}, {63'd0, (exp[31:0] == 32'd0)});
    endtask

    initial begin
        int n;
        logic bok;
        logic saw_done;

        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_out", aluout_o, 64'd0);
        chk("rst_zero", {63'd0, zero_o}, 64'd0);
        rst = 1'b0;

        single("add",  ALUOP_ADD,  32'h7FFFFFFF, 32'd1, 64'h0000_0000_8000_0000, 1'b0);
        single("sub",  ALUOP_SUB,  32'h1234, 32'h1234, 64'd0, 1'b1);
        single("sra",  ALUOP_SRA,  32'd4, 32'h8000_0000, 64'h0000_0000_F800_0000, 1'b0);
        single("srl",  ALUOP_SRL,  32'd4, 32'h8000_0000, 64'h0000_0000_0800_0000, 1'b0);
        single("sll",  ALUOP_SLL,  32'd36, 32'd1, 64'h10, 1'b0);
        single("slt",  ALUOP_SLT,  32'hFFFF_FFFF, 32'd1, 64'd1, 1'b0);
        single("sltu", ALUOP_SLTU, 32'hFFFF_FFFF, 32'd1, 64'd0, 1'b1);
        single("lui",  ALUOP_LUI,  32'd0, 32'h1234_ABCD, 64'h0000_0000_ABCD_0000, 1'b0);
        single("nor",  ALUOP_NOR,  32'h0F0F_0000, 32'h0000_00F0, 64'h0000_0000_F0F0_FF0F, 1'b0);
        single("and",  ALUOP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 64'h0000_0000_0F00_0F00, 1'b0);
        single("bad",  5'd31,      32'd5, 32'd6, 64'd0, 1'b1);

        multi("mult",   ALUOP_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        // New request in the done cycle: accepted, completes one cycle later.
        start_i = 1'b1; aluop_i = ALUOP_ADD; src0_i = 32'd1; src1_i = 32'd1;
        @(negedge clk);
        start_i = 1'b0;
        chk("b2b_done", {63'd0, done_o}, 64'd1);
        chk("b2b_out", aluout_o, 64'd2);

        multi("div",    ALUOP_DIV,  32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        multi("divu0",  ALUOP_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
        multi("div0",   ALUOP_DIV,  32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);
        multi("divovf", ALUOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        multi("divu",   ALUOP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        multi("multu1", ALUOP_MULTU, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780);

        // Start during busy is ignored.
        issue(ALUOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 1;
        repeat (9) begin @(negedge clk); n++; end
        start_i = 1'b1; aluop_i = ALUOP_ADD; src0_i = 32'd1; src1_i = 32'd1;
        @(negedge clk);
        n++;
        start_i = 1'b0;
        wait_done(n, n, bok);
        chk("ign_lat", 64'(n), 64'd34);
        chk("ign_out", aluout_o, 64'hFFFF_FFFE_0000_0001);
        chk("ign_zero", {63'd0, zero_o}, 64'd0);

        // Reset mid-division discards the operation.
        issue(ALUOP_DIVU, 32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", {63'd0, busy_o}, 64'd0);
        chk("mrst_done", {63'd0, done_o}, 64'd0);
        chk("mrst_out", aluout_o, 64'd0);
        chk("mrst_zero", {63'd0, zero_o}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_o || busy_o) saw_done = 1'b1;
        end
        chk("mrst_nodone", {63'd0, saw_done}, 64'd0);
        single("post", ALUOP_ADD, 32'd20, 32'd22, 64'd42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Multi-cycle ALU that services the operation-request interface driven by the vector-driven ALU bench and, later, by the EX stage.
- Accepts one request (aluop, src0, src1) per start pulse.
- Completes logic/add/shift ops in 1 cycle and MULT/MULTU/DIV/DIVU iteratively in 34 cycles.
- Returns a 64-bit {hi,lo} result, a zero flag, and a done pulse.

Parameters:
- XLEN, 32, operand width; result is 2*XLEN.
- ITER, 32, mult/div iteration count; must equal XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request valid; sampled only when busy_o=0.
- aluop_i  input  5  operation code, ALUOP_* encoding.
- src0_i  input  32  operand 0; shift amount for shifts.
- src1_i  input  32  operand 1; shifted value for shifts and LUI.
- busy_o  output  1  high from the cycle after acceptance until done_o.
- done_o  output  1  one-cycle pulse; aluout_o/zero_o valid in that cycle.
- aluout_o  output  64  {hi,lo} result; held until the next acceptance.
- zero_o  output  1  aluout_o[31:0]==0; registered with aluout_o.

Behaviour:
- Reset, synchronous, active-high: busy_o=0, done_o=0, aluout_o=0, zero_o=0. Any in-flight op is discarded; no done_o pulse follows.
- Acceptance: start_i=1 while in IDLE. Operands and aluop are latched at that edge. start_i while busy_o=1 is ignored and not queued.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE + start + single-cycle op -> DONE.
  - IDLE + start + MULT/MULTU/DIV/DIVU -> CALC.
  - CALC -> FIX after the ITER-th iteration.
  - FIX -> DONE.
  - DONE -> IDLE. done_o=1 only in DONE.
  - DONE accepts a new start_i. That start is treated as if in IDLE, giving back-to-back ops with no bubble.
- Latency from the acceptance edge:
  - single-cycle ops: done_o high 1 cycle later.
  - mult/div: done_o high 34 cycles later (32 CALC + 1 FIX + 1 DONE).
- Single-cycle ops; all set aluout_o[63:32]=0:
  - NOP: lo=0.
  - ADD, SUB: lo=src0±src1 mod 2^32, no overflow trap.
  - SLT: lo=signed src0<src1. SLTU: lo=unsigned src0<src1.
  - AND, OR: bitwise. NOR: ~(src0|src1).
  - LUI: lo={src1[15:0],16'h0}.
  - SLL, SRL, SRA: src1 shifted by src0[4:0]; SRA is arithmetic.
  - Unknown opcode: same as NOP.
- MULTU: shift-add, one multiplier bit per CALC cycle; {hi,lo}=src0*src1 unsigned.
- MULT: magnitudes are multiplied. FIX negates the 64-bit product when sign0^sign1.
- DIVU: restoring division, one quotient bit per CALC cycle; lo=quotient, hi=remainder.
- DIV: magnitudes are divided. FIX negates the quotient when sign0^sign1 and negates the remainder when src0 is negative (remainder takes the dividend's sign).
- Divide by zero, signed or unsigned: lo=32'hFFFFFFFF, hi=src0. Still takes 34 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- zero_o is valid for every op and is updated together with aluout_o at the DONE entry edge.

Decomposition:
- ALUOP_* codes stay in the shared defines.v; the testbench and this block use the same encodings.
- Add to defines.v: localparams for FSM state encodings and the ITER count.
- One sub-module: mdu_iter. It holds the iterative unsigned shift-add multiplier and the restoring divider, which share a 64-bit accumulator and a 6-bit counter.
- alu_mc owns operand latching, sign pre/post processing, the single-cycle datapath, and the FSM.

Test Plan:
- ADD src0=0x7FFFFFFF, src1=1 -> done_o 1 cycle after start; aluout_o=0x0000_0000_8000_0000, zero_o=0.
- SUB 0x1234/0x1234 -> aluout_o=0, zero_o=1. SRA src0=4, src1=0x80000000 -> lo=0xF8000000.
- MULT src0=0xFFFFFFFE (-2), src1=3 -> done_o exactly 34 cycles after acceptance; aluout_o=0xFFFFFFFF_FFFFFFFA; busy_o high for cycles 1..33.
- DIV src0=0xFFFFFFF9 (-7), src1=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- Second start_i at cycle 10 of a MULTU 0xFFFFFFFF*0xFFFFFFFF -> ignored; result 0xFFFFFFFE_00000001. A start_i in the done_o cycle (ADD 1+1) is accepted; lo=2 one cycle later.
- rst asserted at cycle 20 of a DIVU -> next cycle all outputs 0, no done_o pulse; a new ADD issued afterward completes normally.
